// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam int unsigned INSTR_STEP       = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC selection: sequential step or branch target, plus target alignment check.
module pc_next_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] i_instr_pc,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_imm,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_misaligned
);

  logic [ADDR_W-1:0] w_pc_seq;
  logic [ADDR_W-1:0] w_pc_target;

  // Both sums wrap modulo 2^ADDR_W.
  assign w_pc_seq     = i_instr_pc + ADDR_W'(INSTR_STEP);
  assign w_pc_target  = i_instr_pc + i_branch_imm;
  assign o_pc_next    = i_branch_taken ? w_pc_target : w_pc_seq;
  assign o_misaligned = i_branch_taken & (|w_pc_target[1:0]);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, issues one memory request at a time and holds the
// returned instruction until execute accepts it.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W   = 64,
  parameter int unsigned      INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic               i_mem_ready,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_exec_ready,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_imm,
  input  logic               i_halt,
  output logic               o_halted,
  output logic               o_misaligned_fault,
  output logic [63:0]        o_instret
);

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic [63:0]         r_instret;
  logic                r_fault;
  logic [ADDR_W-1:0]   w_pc_next;
  logic                w_misaligned;
  logic                w_capture;
  logic                w_accept;

  pc_next_unit #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .i_instr_pc    (r_instr_pc),
    .i_branch_taken(i_branch_taken),
    .i_branch_imm  (i_branch_imm),
    .o_pc_next     (w_pc_next),
    .o_misaligned  (w_misaligned)
  );

  assign w_capture = (r_state == S_FETCH) & i_mem_ready;
  assign w_accept  = (r_state == S_HOLD) & i_exec_ready;

  // State register; reset abandons any in-flight request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next  = r_state;
    o_mem_req     = 1'b0;
    o_instr_valid = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_exec_ready) begin
          // halt wins over branch; a misaligned redirect also stops the core.
          if (i_halt || w_misaligned) begin
            w_state_next = S_HALTED;
          end else begin
            w_state_next = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // PC, holding register, retire counter and sticky fault.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_instret  <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr    <= i_mem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_accept) begin
        r_instret <= r_instret + 64'd1;
        // A misaligned target is never loaded into the PC; it only faults when not halting.
        if (!w_misaligned) begin
          r_pc <= w_pc_next;
        end else if (!i_halt) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign o_mem_addr         = r_pc;
  assign o_instr            = r_instr;
  assign o_instr_pc         = r_instr_pc;
  assign o_instret          = r_instret;
  assign o_misaligned_fault = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetch addresses and accepted
// instructions; a monitor pops and compares whenever the DUT requests or hands over an instruction.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        exec_ready;
  logic        branch_taken;
  logic [63:0] branch_imm;
  logic        halt;
  logic        halted;
  logic        misaligned_fault;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] addr_q[$];
  logic [95:0] instr_q[$];  // {pc, instr}

  int mem_wait = 0;
  bit tie_high = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W  (64),
    .INSTR_W (32),
    .RESET_PC(64'h0)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .o_mem_req         (mem_req),
    .o_mem_addr        (mem_addr),
    .i_mem_ready       (mem_ready),
    .i_mem_rdata       (mem_rdata),
    .o_instr_valid     (instr_valid),
    .o_instr           (instr),
    .o_instr_pc        (instr_pc),
    .i_exec_ready      (exec_ready),
    .i_branch_taken    (branch_taken),
    .i_branch_imm      (branch_imm),
    .i_halt            (halt),
    .o_halted          (halted),
    .o_misaligned_fault(misaligned_fault),
    .o_instret         (instret)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h00500093 ^ a[31:0];
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_wait cycles of a request, or every cycle when tied high.
  initial begin
    int wcnt;
    bit rdy;
    wcnt      = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        rdy = tie_high || (wcnt >= mem_wait);
        wcnt++;
      end else begin
        rdy  = tie_high;
        wcnt = 0;
      end
      mem_ready = rdy;
      mem_rdata = rdy ? mem_word(mem_addr) : 32'hDEADBEEF;
    end
  end

  // Monitor: checks each new request address (and its stability) and each accepted instruction.
  initial begin
    bit          prev;
    logic [63:0] cur;
    logic [95:0] e;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fetch_addr: request at %h, required no request", mem_addr);
          cur = mem_addr;
        end else begin
          cur = addr_q.pop_front();
        end
      end
      if (mem_req) check64("fetch_addr", mem_addr, cur);
      prev = mem_req;
      if (instr_valid && exec_ready) begin
        if (instr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL accept: instruction at %h accepted, required none", instr_pc);
        end else begin
          e = instr_q.pop_front();
          check64("accept_pc", instr_pc, e[95:32]);
          check64("accept_instr", {32'h0, instr}, {32'h0, e[31:0]});
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check64({tag, "_mem_req"}, {63'h0, mem_req}, 64'h0);
    check64({tag, "_instr_valid"}, {63'h0, instr_valid}, 64'h0);
    check64({tag, "_halted"}, {63'h0, halted}, 64'h0);
    check64({tag, "_fault"}, {63'h0, misaligned_fault}, 64'h0);
    check64({tag, "_instret"}, instret, 64'h0);
    check64({tag, "_instr"}, {32'h0, instr}, 64'h0);
    check64({tag, "_instr_pc"}, instr_pc, 64'h0);
    check64({tag, "_pc"}, mem_addr, 64'h0);
  endtask

  // Leaves reset low at posedge+1 with the DUT in IDLE.
  task automatic do_reset();
    reset        = 1'b1;
    exec_ready   = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    halt         = 1'b0;
    tie_high     = 1'b0;
    mem_wait     = 0;
    @(posedge clk);
    #1;
    check64("drain_addr_q", 64'(addr_q.size()), 64'h0);
    check64("drain_instr_q", 64'(instr_q.size()), 64'h0);
    addr_q.delete();
    instr_q.delete();
    check_outputs_zero("reset");
    reset = 1'b0;
  endtask

  // Waits (bounded) for a held instruction, then accepts it with the given redirect controls.
  task automatic accept_one(input logic [63:0] exp_pc, input bit br, input logic [63:0] imm,
                            input bit hl);
    int i;
    i = 0;
    while (!instr_valid && i < 50) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (!instr_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: instr_valid=0 at pc %h, required 1", exp_pc);
      return;
    end
    instr_q.push_back({exp_pc, mem_word(exp_pc)});
    exec_ready   = 1'b1;
    branch_taken = br;
    branch_imm   = imm;
    halt         = hl;
    @(posedge clk);
    #1;
    exec_ready   = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    halt         = 1'b0;
  endtask

  initial begin
    int cnt;
    reset        = 1'b1;
    exec_ready   = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = '0;
    halt         = 1'b0;
    @(posedge clk);
    #1;

    // 1: zero-wait memory, continuous accept, straight-line code.
    do_reset();
    tie_high   = 1'b1;
    exec_ready = 1'b1;
    for (int a = 0; a <= 16; a += 4) addr_q.push_back(64'(a));
    for (int a = 0; a <= 12; a += 4) instr_q.push_back({64'(a), mem_word(64'(a))});
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      check64("t1_valid", {63'h0, instr_valid}, {63'h0, k % 2 == 0});
      check64("t1_req", {63'h0, mem_req}, {63'h0, k % 2 == 1});
    end
    check64("t1_instret", instret, 64'd4);

    // 3: stall HOLD at 0x10 for five cycles, then accept.
    @(posedge clk);
    #1;
    exec_ready = 1'b0;
    tie_high   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check64("t3_valid", {63'h0, instr_valid}, 64'h1);
      check64("t3_instr_pc", instr_pc, 64'h10);
      check64("t3_instr", {32'h0, instr}, {32'h0, mem_word(64'h10)});
      check64("t3_no_req", {63'h0, mem_req}, 64'h0);
      @(posedge clk);
      #1;
    end
    addr_q.push_back(64'h14);
    accept_one(64'h10, 1'b0, 64'h0, 1'b0);
    check64("t3_instret", instret, 64'd5);

    // 2: three wait cycles.
    do_reset();
    mem_wait = 3;
    addr_q.push_back(64'h0);
    cnt = 0;
    for (int k = 0; k < 20 && !instr_valid; k++) begin
      @(posedge clk);
      #1;
      if (mem_req) cnt++;
    end
    check64("t2_req_cycles", 64'(cnt), 64'd4);
    check64("t2_instr", {32'h0, instr}, 64'h00500093);
    check64("t2_instr_pc", instr_pc, 64'h0);
    addr_q.push_back(64'h4);
    accept_one(64'h0, 1'b0, 64'h0, 1'b0);

    // 4: backward branch, then misaligned branch.
    do_reset();
    for (int a = 0; a <= 32; a += 4) addr_q.push_back(64'(a));
    addr_q.push_back(64'h18);
    for (int a = 0; a < 32; a += 4) accept_one(64'(a), 1'b0, 64'h0, 1'b0);
    accept_one(64'h20, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    accept_one(64'h18, 1'b1, 64'h6, 1'b0);
    check64("t4_fault", {63'h0, misaligned_fault}, 64'h1);
    check64("t4_halted", {63'h0, halted}, 64'h1);
    check64("t4_instret", instret, 64'd10);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check64("t4_no_req", {63'h0, mem_req}, 64'h0);
    end

    // 5: halt together with an aligned branch.
    do_reset();
    addr_q.push_back(64'h0);
    addr_q.push_back(64'h4);
    accept_one(64'h0, 1'b0, 64'h0, 1'b0);
    accept_one(64'h4, 1'b1, 64'h8, 1'b1);
    check64("t5_instret", instret, 64'd2);
    check64("t5_fault", {63'h0, misaligned_fault}, 64'h0);
    for (int k = 0; k < 3; k++) begin
      check64("t5_halted", {63'h0, halted}, 64'h1);
      check64("t5_valid", {63'h0, instr_valid}, 64'h0);
      check64("t5_no_req", {63'h0, mem_req}, 64'h0);
      @(posedge clk);
      #1;
    end

    // 6: reset lands in a FETCH cycle where memory answers.
    do_reset();
    addr_q.push_back(64'h0);
    addr_q.push_back(64'h4);
    accept_one(64'h0, 1'b0, 64'h0, 1'b0);
    check64("t6_in_fetch", {63'h0, mem_req}, 64'h1);
    check64("t6_ready", {63'h0, mem_ready}, 64'h1);
    reset    = 1'b1;
    tie_high = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("t6");
    reset = 1'b0;
    addr_q.push_back(64'h0);
    check64("t6_cycle1_req", {63'h0, mem_req}, 64'h0);
    @(posedge clk);
    #1;
    check64("t6_cycle2_req", {63'h0, mem_req}, 64'h1);
    @(posedge clk);
    #1;
    check64("t6_valid", {63'h0, instr_valid}, 64'h1);
    check64("t6_instr", {32'h0, instr}, {32'h0, mem_word(64'h0)});
    tie_high = 1'b0;
    @(negedge clk);
    check64("end_addr_q", 64'(addr_q.size()), 64'h0);
    check64("end_instr_q", 64'(instr_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
